// File: rtl/kl_fetch_pkg.sv
// Shared types for the KL10 instruction prefetch path: fetch FSM states,
// address/word widths and the queued {word, pc} entry.
package kl_fetch_pkg;

  localparam int KL_PCW    = 18;
  localparam int KL_WORD_W = 36;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DISCARD
  } fetch_state_t;

  typedef struct packed {
    logic [0:KL_WORD_W-1] word;
    logic [KL_PCW-1:0]    pc;
  } fifo_entry_t;

endpackage

// File: rtl/ir_prefetch_if.sv
// Cache-side, EBOX-side and IR-side signals of the prefetch queue.
interface ir_prefetch_if
  import kl_fetch_pkg::*;
#(
  parameter int PCW   = KL_PCW,
  parameter int DEPTH = 4
);
  logic                   fetchEnable;
  logic                   redirect;
  logic [PCW-1:0]         redirectPC;
  logic                   cacheReq;
  logic [PCW-1:0]         cacheAddr;
  logic                   cacheAck;
  logic [0:KL_WORD_W-1]   cacheData;
  logic                   irValid;
  logic [0:KL_WORD_W-1]   irWord;
  logic [PCW-1:0]         irPC;
  logic                   irTake;
  logic                   loadIR;
  logic [$clog2(DEPTH):0] level;

  modport master (
    input  fetchEnable, redirect, redirectPC, cacheAck, cacheData, irTake,
    output cacheReq, cacheAddr, irValid, irWord, irPC, loadIR, level
  );

  modport slave (
    output fetchEnable, redirect, redirectPC, cacheAck, cacheData, irTake,
    input  cacheReq, cacheAddr, irValid, irWord, irPC, loadIR, level
  );
endinterface

// File: rtl/ir_prefetch_fifo.sv
// DEPTH-entry synchronous FIFO of {word, pc}; separate level counter keeps
// full and empty unambiguous. Head reads zero while empty.
module ir_prefetch_fifo
  import kl_fetch_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int LVL_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic             push,
  input  fifo_entry_t      push_data,
  input  logic             pop,
  input  logic             flush,
  output fifo_entry_t      head,
  output logic [LVL_W-1:0] level
);

  fifo_entry_t      mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_pop;

  assign do_pop = pop && (level != '0);
  assign head   = (level != '0) ? mem[rd_ptr] : '0;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop) rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !do_pop)      level <= level + LVL_W'(1);
      else if (do_pop && !push) level <= level - LVL_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= push_data;
  end

  // The fetch side reserves a slot before requesting, so this never fires.
  push_not_full: assert property (@(posedge clk) disable iff (!resetN)
    push |-> (level != LVL_W'(DEPTH)));

endmodule

// File: rtl/ir_prefetch.sv
// Instruction prefetch queue ahead of IR: sequential cache fetch, buffering
// of returned words with their PCs, and load-IR strobe generation.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | no request outstanding; issue when enabled and a slot is free
// FETCH   | request outstanding; its word will be queued on ack
// DISCARD | request outstanding but made stale by a redirect; drop on ack
module ir_prefetch
  import kl_fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PCW   = KL_PCW
) (
  input logic           clk,
  input logic           resetN,
  ir_prefetch_if.master bus
);

  localparam int LVL_W = $clog2(DEPTH) + 1;

  fetch_state_t     state;
  logic [PCW-1:0]   fetch_pc;
  logic [PCW-1:0]   cache_addr_q;
  logic             cache_req_q;
  logic             push;
  logic             pop;
  logic             slot_free;
  fifo_entry_t      push_entry;
  fifo_entry_t      head;
  logic [LVL_W-1:0] level;

  assign pop        = bus.irTake && bus.irValid && !bus.redirect;
  assign push       = (state == FETCH) && bus.cacheAck && !bus.redirect;
  assign push_entry = '{word: bus.cacheData, pc: KL_PCW'(cache_addr_q)};
  assign slot_free  = (int'(level) + int'(state != IDLE)) < DEPTH;

  ir_prefetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .resetN    (resetN),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .flush     (bus.redirect),
    .head      (head),
    .level     (level)
  );

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state        <= IDLE;
      fetch_pc     <= '0;
      cache_req_q  <= 1'b0;
      cache_addr_q <= '0;
    end else begin
      if (bus.redirect) fetch_pc <= bus.redirectPC;
      else if (push)    fetch_pc <= fetch_pc + PCW'(1);

      case (state)
        IDLE: begin
          if (bus.fetchEnable && !bus.redirect && slot_free) begin
            state        <= FETCH;
            cache_req_q  <= 1'b1;
            cache_addr_q <= fetch_pc;
          end
        end
        FETCH: begin
          // A same-cycle redirect drops the acked word via the push gate.
          if (bus.cacheAck) begin
            state       <= IDLE;
            cache_req_q <= 1'b0;
          end else if (bus.redirect) begin
            state <= DISCARD;
          end
        end
        DISCARD: begin
          if (bus.cacheAck) begin
            state       <= IDLE;
            cache_req_q <= 1'b0;
          end
        end
        default: begin
          state       <= IDLE;
          cache_req_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.cacheReq  = cache_req_q;
  assign bus.cacheAddr = cache_addr_q;
  assign bus.irValid   = (level != '0);
  assign bus.irWord    = head.word;
  assign bus.irPC      = PCW'(head.pc);
  assign bus.loadIR    = pop;
  assign bus.level     = level;

endmodule
